// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, RCON table,
// FSM state encoding, key/word types and a computed S-box function.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    EMIT
  } state_t;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Exponent 254 gives the multiplicative inverse in GF(2^8).
  localparam logic [7:0] INV_EXP = 8'hfe;

  // Out-of-range indices (e.g. rc-1 with rc==0) map to zero.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (idx == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] acc;
    r   = 8'h01;
    acc = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (INV_EXP[i]) r = gf_mul(r, acc);
      acc = gf_mul(acc, acc);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_step_dual.sv
// One combinational AES-128 key-schedule step, forward (dir=0) or
// inverse (dir=1). Four S-boxes are shared by both directions; only the
// word fed to SubWord differs (w3 forward, w3^w2 inverse).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  assign s = sbox(a);
endmodule

module key_step_dual
  import aes_pkg::*;
(
  input  logic [127:0] w,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] w_next
);

  word_t w0, w1, w2, w3;
  word_t p3, sel, rot, sub, t;
  word_t f0, f1, f2, f3;

  assign w0 = w[127:96];
  assign w1 = w[95:64];
  assign w2 = w[63:32];
  assign w3 = w[31:0];

  // In the inverse direction the previous w3 is recovered first so that
  // the same SubWord(RotWord()) path can rebuild the previous w0.
  assign p3  = w3 ^ w2;
  assign sel = dir ? p3 : w3;
  assign rot = {sel[23:0], sel[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a(rot[8*i +: 8]),
      .s(sub[8*i +: 8])
    );
  end

  assign t = sub ^ {rcon, 24'h000000};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // Select forward chain or inverse reconstruction.
  always_comb begin
    w_next = {f0, f1, f2, f3};
    if (dir) w_next = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
  end

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 decryption round-key generator: expands the cipher key forward
// to round 10 in a single working register, then walks the schedule
// backwards, streaming round keys 10..0 over valid/ready.
// Optional build macro: INV_KEY_CHECK_EN (adds chk_err reconstruction check).
module inv_key_schedule #(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last
`ifdef INV_KEY_CHECK_EN
  ,
  output logic         chk_err
`endif
);

  import aes_pkg::*;

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("inv_key_schedule: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LAST_RC = 4'(NR);

  state_t       state;
  logic [127:0] w;
  logic [127:0] w_next;
  logic [3:0]   rc;
  logic [3:0]   rc_idx;
  logic [7:0]   rcon;
  logic         dir;

`ifdef INV_KEY_CHECK_EN
  logic [127:0] k0;
`endif

  assign dir    = (state == EMIT);
  assign rc_idx = dir ? rc - 4'd1 : rc;
  assign rcon   = rcon_at(rc_idx);
  assign rk_out = w;

  key_step_dual u_step (
    .w     (w),
    .rcon  (rcon),
    .dir   (dir),
    .w_next(w_next)
  );

  // Load / expand / emit FSM with the working key register and stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w        <= '0;
      rc       <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
`ifdef INV_KEY_CHECK_EN
      k0       <= '0;
      chk_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            w     <= key_in;
            rc    <= '0;
            busy  <= 1'b1;
            state <= EXPAND;
`ifdef INV_KEY_CHECK_EN
            k0      <= key_in;
            chk_err <= 1'b0;
`endif
          end
        end
        EXPAND: begin
          w  <= w_next;
          rc <= rc + 4'd1;
          if (rc == LAST_RC - 4'd1) begin
            state    <= EMIT;
            rk_valid <= 1'b1;
            rk_round <= LAST_RC;
            rk_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rc != 4'd0) begin
              w        <= w_next;
              rc       <= rc - 4'd1;
              rk_round <= rc - 4'd1;
              rk_last  <= (rc == 4'd1);
            end else begin
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
`ifdef INV_KEY_CHECK_EN
              chk_err  <= (w != k0);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: reference AES-128 key expansion (word array,
// generated S-box table) checked against the streamed round keys.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         rk_last;
`ifdef INV_KEY_CHECK_EN
  logic         chk_err;
  logic [127:0] bad_w;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] r10;
    logic [127:0] r1;
  } vec_t;

  vec_t tbl [2];

  inv_key_schedule #(.NR(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .key_load(key_load),
    .busy    (busy),
    .rk_out  (rk_out),
    .rk_round(rk_round),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk_last (rk_last)
`ifdef INV_KEY_CHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // S-box table from the log/antilog walk over generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Textbook 44-word expansion; exp_rk[r] is the round-r key.
  task automatic model(input logic [127:0] key);
    logic [31:0] wd [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
  endtask

  // Called at a negedge: pulses key_load for one cycle.
  task automatic start_load(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    chk("busy_after_load", 128'(busy), 128'd1);
  endtask

  // Consume the 11 round keys, checking each against exp_rk and holding
  // stability while stalled. Optional junk loads while busy; b2b leaves
  // key_load asserted on the rk_last handshake.
  task automatic collect(input int unsigned ready_pct, input bit inject, input bit b2b);
    int   idx, cyc, first;
    bit   stalled;
    logic [127:0] pk;
    logic [3:0]   pr;
    idx = 10; cyc = 0; first = -1; stalled = 1'b0; pk = '0; pr = '0;
    while (idx >= 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (rk_valid && first < 0) first = cyc;
      if (rk_valid) begin
        if (stalled) begin
          chk("stall_key", rk_out, pk);
          chk("stall_round", 128'(rk_round), 128'(pr));
        end
        rk_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (rk_ready) begin
          chk("round", 128'(rk_round), 128'(idx));
          chk($sformatf("rk%0d", idx), rk_out, exp_rk[idx]);
          chk("last", 128'(rk_last), 128'(idx == 0));
          got_rk[idx] = rk_out;
          idx--;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pk = rk_out;
          pr = rk_round;
        end
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
      end
      if (b2b && idx < 0) begin
        key_load = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
      end else if (inject) begin
        key_load = ($urandom_range(0, 3) == 0);
        key_in   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        key_load = 1'b0;
      end
    end
    if (idx >= 0) begin
      n_vec++;
      n_err++;
      $display("FAIL collect_timeout: got %0d keys left, required 0", idx + 1);
    end
    if (ready_pct >= 100) chk("first_valid_cycles", 128'(first), 128'd10);
  endtask

  // Negedge after the final handshake: idle, round-0 key held.
  task automatic post(input logic [127:0] key, input bit keep_load);
    @(negedge clk);
    if (!keep_load) key_load = 1'b0;
    chk("post_valid", 128'(rk_valid), 128'd0);
    chk("post_busy", 128'(busy), 128'd0);
    chk("post_last", 128'(rk_last), 128'd0);
    chk("post_round", 128'(rk_round), 128'd0);
    chk("post_hold", rk_out, key);
`ifdef INV_KEY_CHECK_EN
    chk("post_chk_err", 128'(chk_err), 128'd0);
`endif
  endtask

  initial begin
    logic [127:0] k1, k2;
    bit found;

    tbl[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               r1:  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[1] = '{key: 128'h0,
               r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
               r1:  128'h62636363626363636263636362636363};

    build_sbox();

    #2 rst_n = 1'b0;
    #1;
    chk("reset_rk_out", rk_out, 128'd0);
    chk("reset_round", 128'(rk_round), 128'd0);
    chk("reset_valid", 128'(rk_valid), 128'd0);
    chk("reset_last", 128'(rk_last), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
`ifdef INV_KEY_CHECK_EN
    chk("reset_chk_err", 128'(chk_err), 128'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer table, rk_ready held high
    for (int i = 0; i < 2; i++) begin
      model(tbl[i].key);
      @(negedge clk);
      start_load(tbl[i].key);
      collect(100, 1'b0, 1'b0);
      post(tbl[i].key, 1'b0);
      chk($sformatf("tbl%0d_r10", i), got_rk[10], tbl[i].r10);
      chk($sformatf("tbl%0d_r1", i), got_rk[1], tbl[i].r1);
      chk($sformatf("tbl%0d_r0", i), got_rk[0], tbl[i].key);
    end

    // Backpressure, then loads pulsed while busy
    model(tbl[0].key);
    @(negedge clk);
    start_load(tbl[0].key);
    collect(50, 1'b0, 1'b0);
    post(tbl[0].key, 1'b0);

    @(negedge clk);
    start_load(tbl[0].key);
    collect(70, 1'b1, 1'b0);
    post(tbl[0].key, 1'b0);

    // Random keys with random backpressure and stray loads
    for (int i = 0; i < 4; i++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      model(k1);
      @(negedge clk);
      start_load(k1);
      collect(60, 1'b1, 1'b0);
      post(k1, 1'b0);
    end

    // Reset while emitting round 5
    @(negedge clk);
    start_load(tbl[0].key);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      rk_ready = 1'b1;
      @(negedge clk);
      if (rk_valid && rk_round == 4'd5) found = 1'b1;
    end
    chk("reset_mid_found", 128'(found), 128'd1);
    rk_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_rk_out", rk_out, 128'd0);
    chk("mid_reset_round", 128'(rk_round), 128'd0);
    chk("mid_reset_valid", 128'(rk_valid), 128'd0);
    chk("mid_reset_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rk_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_partial_valid", 128'(rk_valid), 128'd0);
    end
    model(tbl[1].key);
    start_load(tbl[1].key);
    collect(100, 1'b0, 1'b0);
    post(tbl[1].key, 1'b0);
    chk("after_reset_r10", got_rk[10], tbl[1].r10);

    // Back-to-back: load raised on rk_last handshake (ignored), held one
    // more cycle with a new key (accepted).
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    model(k1);
    @(negedge clk);
    start_load(k1);
    collect(100, 1'b0, 1'b1);
    post(k1, 1'b1);
    key_in = k2;
    @(negedge clk);
    key_load = 1'b0;
    chk("b2b_busy", 128'(busy), 128'd1);
    chk("b2b_loaded", rk_out, k2);
    model(k2);
    collect(100, 1'b0, 1'b0);
    post(k2, 1'b0);

`ifdef INV_KEY_CHECK_EN
    // Corrupt W while stalled mid-emit; chk_err must latch at round 0
    @(negedge clk);
    start_load(tbl[0].key);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      rk_ready = 1'b1;
      @(negedge clk);
      if (rk_valid && rk_round == 4'd7) found = 1'b1;
    end
    rk_ready = 1'b0;
    bad_w = rk_out ^ 128'h1;
    force dut.w = bad_w;
    @(negedge clk);
    release dut.w;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      rk_ready = 1'b1;
      if (rk_valid && rk_last) found = 1'b1;
      @(negedge clk);
    end
    chk("chk_err_set", 128'(chk_err), 128'd1);
    @(negedge clk);
    chk("chk_err_sticky", 128'(chk_err), 128'd1);
    model(tbl[1].key);
    start_load(tbl[1].key);
    chk("chk_err_cleared", 128'(chk_err), 128'd0);
    collect(100, 1'b0, 1'b0);
    post(tbl[1].key, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
